// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_req,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  output logic                    f_done,
  output logic                    f_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_done,
  output logic                    d_err,
  output logic                    m_valid,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ready,
  output logic                    busy
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            last_grant_q;  // 1 = data port won last
  logic            winner_q;      // 1 = data port owns the current transaction
  logic            err_q;
  logic            grant_data;
  logic            timeout_hit;

  assign grant_data  = d_req & (~f_req | ~last_grant_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (f_req || d_req) state_d = ACCESS;
      ACCESS:  if (m_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      err_q        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_wstrb      <= '0;
      f_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          err_q <= 1'b0;
          if (f_req || d_req) begin
            winner_q     <= grant_data;
            last_grant_q <= grant_data;
            m_we         <= grant_data & d_we;
            m_addr       <= grant_data ? d_addr : f_addr;
            m_wdata      <= grant_data ? d_wdata : '0;
            m_wstrb      <= (grant_data && d_we) ? d_wstrb : '0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          // m_ready in the last timeout cycle still completes normally
          if (m_ready) begin
            err_q <= 1'b0;
            if (winner_q) d_rdata <= m_rdata;
            else          f_rdata <= m_rdata;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (winner_q) d_rdata <= '0;
            else          f_rdata <= '0;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign m_valid = (state_q == ACCESS);
  assign busy    = (state_q != IDLE);
  assign f_done  = (state_q == RESP) && !winner_q;
  assign d_done  = (state_q == RESP) && winner_q;
  assign f_err   = f_done & err_q;
  assign d_err   = d_done & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a scripted memory responder
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        f_done, f_err, d_done, d_err, m_valid, m_we, busy;
  logic [3:0]  m_wstrb;
  logic        m_ready = 1'b0;
  logic        f_req, d_req;

  int f_issue = 0, f_served = 0, d_issue = 0, d_served = 0;
  int mem_wait = 0, vcnt = 0;
  bit mem_never = 1'b0, stray = 1'b0;
  logic [31:0] mem_key = '0;
  int checks = 0, errors = 0;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          vlen;
  } exp_t;
  exp_t exp_q[$];

  assign f_req   = (f_issue != f_served);
  assign d_req   = (d_issue != d_served);
  assign m_rdata = m_addr ^ mem_key;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(bit port, logic [31:0] rdata, bit err, logic [31:0] addr,
                              bit we, logic [31:0] wdata, logic [3:0] wstrb, int vlen);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err; e.addr = addr;
    e.we = we; e.wdata = wdata; e.wstrb = wstrb; e.vlen = vlen;
    return e;
  endfunction

  // Memory responder: ready after mem_wait cycles of m_valid, or never
  always @(negedge clk) begin
    if (m_valid && !mem_never && vcnt == mem_wait) m_ready = 1'b1;
    else                                           m_ready = stray;
    if (m_valid) vcnt = vcnt + 1;
    else         vcnt = 0;
  end

  // Requesters drop a request in the cycle its done pulse is seen
  always @(negedge clk) begin
    if (rst && f_done) f_served = f_served + 1;
    if (rst && d_done) d_served = d_served + 1;
  end

  // Monitor
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_wstrb;
  int          vlen = 0;
  bit          prev_v = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (m_valid) begin
        if (!prev_v) begin
          cap_addr = m_addr; cap_we = m_we; cap_wdata = m_wdata; cap_wstrb = m_wstrb;
          vlen = 0;
        end else begin
          chk("m_addr_hold", {32'd0, m_addr}, {32'd0, cap_addr});
        end
        vlen = vlen + 1;
      end
      if (f_done || d_done) begin
        exp_t e;
        chk("done_onehot", {63'd0, f_done & d_done}, 64'd0);
        chk("done_pulse_width", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: f_done=%0b d_done=%0b expected none at %0t", f_done, d_done, $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_port", {63'd0, d_done}, {63'd0, e.port});
          chk("rdata", {32'd0, e.port ? d_rdata : f_rdata}, {32'd0, e.rdata});
          chk("err", {63'd0, e.port ? d_err : f_err}, {63'd0, e.err});
          chk("m_addr", {32'd0, cap_addr}, {32'd0, e.addr});
          chk("m_we", {63'd0, cap_we}, {63'd0, e.we});
          chk("m_wstrb", {60'd0, cap_wstrb}, {60'd0, e.wstrb});
          if (e.we) chk("m_wdata", {32'd0, cap_wdata}, {32'd0, e.wdata});
          chk("m_valid_cycles", 64'(vlen), 64'(e.vlen));
          chk("m_valid_low_at_done", {63'd0, m_valid}, 64'd0);
        end
      end
      prev_v = m_valid;
      prev_done = f_done | d_done;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: %0d transactions still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_m_bus", {m_addr, m_wdata}, 64'd0);
    chk("rst_m_ctl", {59'd0, m_we, m_wstrb}, 64'd0);
    chk("rst_rdata", {f_rdata, d_rdata}, 64'd0);
    chk("rst_done_err", {60'd0, f_done, d_done, f_err, d_err}, 64'd0);
    rst = 1'b1;

    // Zero-wait fetch
    @(negedge clk);
    mem_key = 32'h0050_0097; mem_wait = 0; f_addr = 32'h4;
    exp_q.push_back(mk(1'b0, 32'h0050_0093, 1'b0, 32'h4, 1'b0, 32'h0, 4'h0, 1));
    f_issue++;
    @(negedge clk);
    chk("fetch_m_valid_latency", {63'd0, m_valid}, 64'd1);
    @(negedge clk);
    chk("fetch_done_latency", {62'd0, f_done, f_err}, 64'd2);
    drain(50);

    // Store with two wait states
    mem_key = 32'h1111_1111; mem_wait = 2;
    d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'h3;
    exp_q.push_back(mk(1'b1, 32'h1111_1011, 1'b0, 32'h100, 1'b1, 32'hDEAD_BEEF, 4'h3, 3));
    d_issue++;
    drain(50);

    // Ready arriving in the last timeout cycle is a success
    mem_wait = 3; f_addr = 32'h8;
    exp_q.push_back(mk(1'b0, 32'h1111_1119, 1'b0, 32'h8, 1'b0, 32'h0, 4'h0, 4));
    f_issue++;
    drain(50);

    // Load that times out, then a normal fetch
    mem_never = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    exp_q.push_back(mk(1'b1, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 4));
    d_issue++;
    drain(50);
    chk("timeout_d_rdata_zero", {32'd0, d_rdata}, 64'd0);
    mem_never = 1'b0; mem_wait = 0; f_addr = 32'hC;
    exp_q.push_back(mk(1'b0, 32'h1111_111D, 1'b0, 32'hC, 1'b0, 32'h0, 4'h0, 1));
    f_issue++;
    drain(50);

    // Stray ready while idle, then f_addr changed mid-access
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    mem_wait = 2; f_addr = 32'h20;
    exp_q.push_back(mk(1'b0, 32'h1111_1131, 1'b0, 32'h20, 1'b0, 32'h0, 4'h0, 3));
    f_issue++;
    @(negedge clk);
    f_addr = 32'h40;
    drain(50);

    // Reset mid-access abandons the fetch without a done pulse
    mem_never = 1'b1; f_addr = 32'h44;
    f_issue++;
    @(negedge clk);
    chk("abort_m_valid_before", {63'd0, m_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_m_valid_async", {63'd0, m_valid}, 64'd0);
    chk("abort_busy_async", {63'd0, busy}, 64'd0);
    chk("abort_no_done", {62'd0, f_done, d_done}, 64'd0);
    f_issue = f_served;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_never = 1'b0;

    // Contention from reset: fetch, data, fetch
    @(negedge clk);
    mem_wait = 1; f_addr = 32'h50; d_addr = 32'h60;
    exp_q.push_back(mk(1'b0, 32'h1111_1141, 1'b0, 32'h50, 1'b0, 32'h0, 4'h0, 2));
    exp_q.push_back(mk(1'b1, 32'h1111_1171, 1'b0, 32'h60, 1'b0, 32'h0, 4'h0, 2));
    exp_q.push_back(mk(1'b0, 32'h1111_1141, 1'b0, 32'h50, 1'b0, 32'h0, 4'h0, 2));
    f_issue = f_issue + 2;
    d_issue++;
    drain(80);
    chk("d_rdata_held", {32'd0, d_rdata}, {32'd0, 32'h1111_1171});
    chk("all_served", {f_issue == f_served, d_issue == d_served}, 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
